// File: rtl/rvb_pkg.sv
// Shared definitions for the bit-manip shifter issue slice.
package rvb_pkg;

  localparam int unsigned RVB_XLEN_MAX = 64;
  localparam int unsigned RVB_TAGW_MAX = 5;
  localparam int unsigned CTL_W        = 6;

  // Bit positions of the copied instruction bits inside ctl
  localparam int unsigned CTL_I3  = 0;
  localparam int unsigned CTL_I14 = 1;
  localparam int unsigned CTL_I26 = 2;
  localparam int unsigned CTL_I27 = 3;
  localparam int unsigned CTL_I29 = 4;
  localparam int unsigned CTL_I30 = 5;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [1:0] F3_SHIFT_LO = 2'b01;   // funct3[1:0] of all shift/rotate/single-bit ops
  localparam logic [2:0] F3_BFP      = 3'b111;

  typedef struct packed {
    logic [RVB_XLEN_MAX-1:0] rs1;
    logic [RVB_XLEN_MAX-1:0] rs2;
    logic [RVB_XLEN_MAX-1:0] rs3;
    logic [CTL_W-1:0]        ctl;
    logic [RVB_TAGW_MAX-1:0] tag;
  } shift_op_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/rvb_shift_decode.sv
// Combinational decode of a raw instruction word into shifter legality,
// immediate selection and the control bits forwarded downstream.
module rvb_shift_decode
  import rvb_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]      insn,
  output logic             legal_c,
  output logic             imm_sel_c,
  output logic [6:0]       imm_c,
  output logic [CTL_W-1:0] ctl_c
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       opc_ok;
  logic       f3_ok;
  logic       rv32_bad;
  logic       unused_insn_bits;

  assign opc = insn[6:0];
  assign f3  = insn[14:12];

  // Register/destination fields and opcode-only bits play no part in shifter control
  assign unused_insn_bits = ^{insn[31], insn[28], insn[19:15], insn[11:7]};

  // Legality, immediate extraction and control bit copy
  always_comb begin
    opc_ok    = (opc == OPC_OP) || (opc == OPC_OP_IMM) ||
                ((XLEN == 64) && ((opc == OPC_OP_32) || (opc == OPC_OP_IMM_32)));
    f3_ok     = (f3[1:0] == F3_SHIFT_LO) || ((f3 == F3_BFP) && insn[27] && !insn[26]);
    // RV32 has no 6-bit shamt: bit 25 set on a non-funnel immediate is reserved
    rv32_bad  = (XLEN == 32) && (opc == OPC_OP_IMM) && insn[25] && !insn[26];
    legal_c   = opc_ok && f3_ok && !rv32_bad;
    imm_sel_c = !opc[5];
    // Funnel immediates reuse bit 26 as an opcode bit, so only 6 shamt bits remain
    imm_c     = insn[26] ? {1'b0, insn[25:20]} : insn[26:20];
    ctl_c          = '0;
    ctl_c[CTL_I3]  = (XLEN == 64) ? insn[3] : 1'b0;
    ctl_c[CTL_I14] = insn[14];
    ctl_c[CTL_I26] = insn[26];
    ctl_c[CTL_I27] = insn[27];
    ctl_c[CTL_I29] = insn[29];
    ctl_c[CTL_I30] = insn[30];
  end

endmodule

// File: rtl/rvb_shift_issue.sv
// Issue stage in front of the bit-manip shifter: decode, immediate
// substitution, illegal-op rejection and output buffering.
// Build option RVB_SHIFT_ISSUE_SKID_EN selects a 2-entry skid buffer with a
// registered in_ready; otherwise a single slot with combinational in_ready.
module rvb_shift_issue
  import rvb_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned TAGW = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs3,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_rs3,
  output logic            out_insn3,
  output logic            out_insn14,
  output logic            out_insn26,
  output logic            out_insn27,
  output logic            out_insn29,
  output logic            out_insn30,
  output logic [TAGW-1:0] out_tag,
  output logic            illegal,
  output logic [TAGW-1:0] illegal_tag
);

  logic             legal_c;
  logic             imm_sel_c;
  logic [6:0]       imm_c;
  logic [CTL_W-1:0] ctl_c;
  shift_op_t        op_c;
  shift_op_t        head_q;
  logic             accept_c;
  logic             push_c;

  rvb_shift_decode #(.XLEN(XLEN)) u_decode (
    .insn      (in_insn),
    .legal_c   (legal_c),
    .imm_sel_c (imm_sel_c),
    .imm_c     (imm_c),
    .ctl_c     (ctl_c)
  );

  // Assemble the op payload with the immediate substituted into rs2
  always_comb begin
    op_c     = '0;
    op_c.rs1 = RVB_XLEN_MAX'(in_rs1);
    op_c.rs2 = imm_sel_c ? RVB_XLEN_MAX'(imm_c) : RVB_XLEN_MAX'(in_rs2);
    op_c.rs3 = RVB_XLEN_MAX'(in_rs3);
    op_c.ctl = ctl_c;
    op_c.tag = RVB_TAGW_MAX'(in_tag);
  end

  assign accept_c = in_valid && in_ready;
  assign push_c   = accept_c && legal_c && !flush;

  // Rejected ops are consumed and reported one cycle later, unless flushed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal     <= 1'b0;
      illegal_tag <= '0;
    end else begin
      illegal <= accept_c && !legal_c && !flush;
      if (accept_c && !legal_c) illegal_tag <= in_tag;
    end
  end

`ifdef RVB_SHIFT_ISSUE_SKID_EN
  buf_state_t state_q;
  buf_state_t state_d;
  shift_op_t  skid_q;
  logic       in_ready_q;
  logic       drain_c;
  logic       head_from_in_c;
  logic       head_from_skid_c;
  logic       skid_load_c;

  assign drain_c  = out_valid && out_ready;
  assign in_ready = in_ready_q;

  // Occupancy next-state and buffer load selects
  always_comb begin
    state_d          = state_q;
    head_from_in_c   = 1'b0;
    head_from_skid_c = 1'b0;
    skid_load_c      = 1'b0;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push_c) begin
            state_d        = BUF_ONE;
            head_from_in_c = 1'b1;
          end
        end
        BUF_ONE: begin
          if (drain_c) begin
            if (push_c) head_from_in_c = 1'b1;
            else        state_d        = BUF_EMPTY;
          end else if (push_c) begin
            skid_load_c = 1'b1;
            state_d     = BUF_TWO;
          end
        end
        BUF_TWO: begin
          // in_ready is low here, so no push can coincide
          if (drain_c) begin
            head_from_skid_c = 1'b1;
            state_d          = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // Occupancy state with registered handshake flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= BUF_EMPTY;
      out_valid  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_valid  <= (state_d != BUF_EMPTY);
      in_ready_q <= (state_d != BUF_TWO);
    end
  end

  // Head and skid payload registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_from_in_c)        head_q <= op_c;
      else if (head_from_skid_c) head_q <= skid_q;
      if (skid_load_c)           skid_q <= op_c;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  // Single output slot: load on push, empty on drain or flush
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      head_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (push_c) begin
      out_valid <= 1'b1;
      head_q    <= op_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign out_rs1    = head_q.rs1[XLEN-1:0];
  assign out_rs2    = head_q.rs2[XLEN-1:0];
  assign out_rs3    = head_q.rs3[XLEN-1:0];
  assign out_tag    = head_q.tag[TAGW-1:0];
  assign out_insn3  = head_q.ctl[CTL_I3];
  assign out_insn14 = head_q.ctl[CTL_I14];
  assign out_insn26 = head_q.ctl[CTL_I26];
  assign out_insn27 = head_q.ctl[CTL_I27];
  assign out_insn29 = head_q.ctl[CTL_I29];
  assign out_insn30 = head_q.ctl[CTL_I30];

endmodule

// File: tb/tb_rvb_shift_issue.sv
// Scoreboard bench for rvb_shift_issue: one XLEN=64 and one XLEN=32 instance.
module tb_rvb_shift_issue;

  typedef struct {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] rs3;
    logic [5:0]  ctl;   // {insn30, insn29, insn27, insn26, insn14, insn3}
    logic [4:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid [2];
  logic [31:0] in_insn  [2];
  logic [63:0] in_rs1   [2];
  logic [63:0] in_rs2   [2];
  logic [63:0] in_rs3   [2];
  logic [4:0]  in_tag   [2];
  logic        flush    [2];
  logic        rdy_dir  [2];
  logic        rdy_rnd  [2];
  logic        rdy_rand [2];
  logic        out_ready[2];

  logic        o64_valid, o64_ready, o64_ill, o64_i3, o64_i14, o64_i26, o64_i27, o64_i29, o64_i30;
  logic [63:0] o64_rs1, o64_rs2, o64_rs3;
  logic [4:0]  o64_tag, o64_itag;
  logic        o32_valid, o32_ready, o32_ill, o32_i3, o32_i14, o32_i26, o32_i27, o32_i29, o32_i30;
  logic [31:0] o32_rs1, o32_rs2, o32_rs3;
  logic [4:0]  o32_tag, o32_itag;

  logic        ov [2];
  logic        oir[2];
  logic        oil[2];
  logic [63:0] ors1[2];
  logic [63:0] ors2[2];
  logic [63:0] ors3[2];
  logic [5:0]  octl[2];
  logic [4:0]  otag[2];
  logic [4:0]  oitag[2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [4:0]  iq0[$];
  logic [4:0]  iq1[$];

  int          errors;
  int          checks;
  bit          stall[2];
  exp_t        snap[2];

  rvb_shift_issue #(.XLEN(64), .TAGW(5)) u_dut64 (
    .clock(clk), .reset(rst), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(o64_ready), .in_insn(in_insn[0]),
    .in_rs1(in_rs1[0]), .in_rs2(in_rs2[0]), .in_rs3(in_rs3[0]), .in_tag(in_tag[0]),
    .out_valid(o64_valid), .out_ready(out_ready[0]),
    .out_rs1(o64_rs1), .out_rs2(o64_rs2), .out_rs3(o64_rs3),
    .out_insn3(o64_i3), .out_insn14(o64_i14), .out_insn26(o64_i26),
    .out_insn27(o64_i27), .out_insn29(o64_i29), .out_insn30(o64_i30),
    .out_tag(o64_tag), .illegal(o64_ill), .illegal_tag(o64_itag)
  );

  rvb_shift_issue #(.XLEN(32), .TAGW(5)) u_dut32 (
    .clock(clk), .reset(rst), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(o32_ready), .in_insn(in_insn[1]),
    .in_rs1(in_rs1[1][31:0]), .in_rs2(in_rs2[1][31:0]), .in_rs3(in_rs3[1][31:0]), .in_tag(in_tag[1]),
    .out_valid(o32_valid), .out_ready(out_ready[1]),
    .out_rs1(o32_rs1), .out_rs2(o32_rs2), .out_rs3(o32_rs3),
    .out_insn3(o32_i3), .out_insn14(o32_i14), .out_insn26(o32_i26),
    .out_insn27(o32_i27), .out_insn29(o32_i29), .out_insn30(o32_i30),
    .out_tag(o32_tag), .illegal(o32_ill), .illegal_tag(o32_itag)
  );

  always_comb begin
    for (int k = 0; k < 2; k++) out_ready[k] = rdy_rand[k] ? rdy_rnd[k] : rdy_dir[k];
    ov[0] = o64_valid;  oir[0] = o64_ready;  oil[0] = o64_ill;
    ors1[0] = o64_rs1;  ors2[0] = o64_rs2;   ors3[0] = o64_rs3;
    octl[0] = {o64_i30, o64_i29, o64_i27, o64_i26, o64_i14, o64_i3};
    otag[0] = o64_tag;  oitag[0] = o64_itag;
    ov[1] = o32_valid;  oir[1] = o32_ready;  oil[1] = o32_ill;
    ors1[1] = 64'(o32_rs1); ors2[1] = 64'(o32_rs2); ors3[1] = 64'(o32_rs3);
    octl[1] = {o32_i30, o32_i29, o32_i27, o32_i26, o32_i14, o32_i3};
    otag[1] = o32_tag;  oitag[1] = o32_itag;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Random downstream readiness, used only when rdy_rand is set
  initial begin
    rdy_rnd[0] = 1'b1;
    rdy_rnd[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) rdy_rnd[k] = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, k, got, exp);
    end
  endtask

  // Reference model straight from the encoding rules
  function automatic bit model(input int xlen, input logic [31:0] insn, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] c, input logic [4:0] tag,
                               output exp_t e);
    int unsigned opc, f3;
    bit opc_ok, f3_ok, rv32_bad;
    logic [63:0] mask;
    opc  = insn & 32'h7F;
    f3   = (insn >> 12) & 32'h7;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    opc_ok   = (opc == 32'h33) || (opc == 32'h13) || (xlen == 64 && (opc == 32'h3B || opc == 32'h1B));
    f3_ok    = ((f3 % 4) == 1) || (f3 == 7 && insn[27] == 1'b1 && insn[26] == 1'b0);
    rv32_bad = (xlen == 32) && (opc == 32'h13) && insn[25] == 1'b1 && insn[26] == 1'b0;
    e.rs1 = a & mask;
    e.rs3 = c & mask;
    if ((opc & 32'h20) == 0)
      e.rs2 = insn[26] ? 64'((insn >> 20) & 32'h3F) : 64'((insn >> 20) & 32'h7F);
    else
      e.rs2 = b & mask;
    e.ctl = {insn[30], insn[29], insn[27], insn[26], insn[14], (xlen == 64) ? insn[3] : 1'b0};
    e.tag = tag;
    return opc_ok && f3_ok && !rv32_bad;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    int unsigned opc, f3;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: opc = 32'h33;
      1: opc = 32'h13;
      2: opc = 32'h3B;
      3: opc = 32'h1B;
      default: opc = $urandom_range(0, 127);
    endcase
    case ($urandom_range(0, 3))
      0: f3 = 1;
      1: f3 = 5;
      2: f3 = 7;
      default: f3 = $urandom_range(0, 7);
    endcase
    if ($urandom_range(0, 2) == 0) begin
      r[27] = 1'b1;
      r[26] = 1'b0;
    end
    return (r & ~32'h0000_707F) | 32'(f3 << 12) | 32'(opc);
  endfunction

  // Present one op at posedge+1; push its expectation at the accepting negedge
  task automatic send(input int k, input logic [31:0] insn, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [4:0] tag, input int max_wait, output bit ok);
    exp_t e;
    bit   legal;
    in_valid[k] = 1'b1;
    in_insn[k]  = insn;
    in_rs1[k]   = a;
    in_rs2[k]   = b;
    in_rs3[k]   = c;
    in_tag[k]   = tag;
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (oir[k]) ok = 1'b1;
    end
    if (ok && !flush[k]) begin
      legal = model((k == 0) ? 64 : 32, insn, a, b, c, tag, e);
      if (k == 0) begin
        if (legal) q0.push_back(e); else iq0.push_back(tag);
      end else begin
        if (legal) q1.push_back(e); else iq1.push_back(tag);
      end
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic send_must(input int k, input logic [31:0] insn, input logic [63:0] b, input logic [4:0] tag);
    bit ok;
    send(k, insn, {$urandom, $urandom}, b, {$urandom, $urandom}, tag, 200, ok);
    check("accept_timeout", k, 64'(ok), 64'd1);
  endtask

  // One flush cycle with an op offered alongside; anything accepted then is dropped
  task automatic flush_cycle(input int k, input logic [31:0] insn, input logic [4:0] tag);
    flush[k]    = 1'b1;
    in_valid[k] = 1'b1;
    in_insn[k]  = insn;
    in_tag[k]   = tag;
    @(negedge clk);
    if (k == 0) q0.delete(); else q1.delete();
    @(posedge clk);
    #1;
    flush[k]    = 1'b0;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    rdy_dir[k] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (n < 60 && ((k == 0) ? (q0.size() + iq0.size()) : (q1.size() + iq1.size())) != 0);
    check("drain_left", k, 64'((k == 0) ? (q0.size() + iq0.size()) : (q1.size() + iq1.size())), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_must(k, rand_insn(), {$urandom, $urandom}, 5'($urandom_range(0, 31)));
    end
  endtask

  // Monitor: scoreboard pops, hold-while-stalled and ready-when-empty checks
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] t;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        stall[k] = 1'b0;
      end else begin
        if (stall[k]) begin
          check("hold_valid", k, 64'(ov[k]), 64'd1);
          check("hold_rs1", k, ors1[k], snap[k].rs1);
          check("hold_rs2", k, ors2[k], snap[k].rs2);
          check("hold_ctl_tag", k, {51'd0, octl[k], otag[k]}, {51'd0, snap[k].ctl, snap[k].tag});
        end
        if (!ov[k]) check("ready_when_empty", k, 64'(oir[k]), 64'd1);
        if (ov[k] && out_ready[k]) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out[%0d]: got tag %0h expected no output", k, otag[k]);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check("out_rs1", k, ors1[k], e.rs1);
            check("out_rs2", k, ors2[k], e.rs2);
            check("out_rs3", k, ors3[k], e.rs3);
            check("out_ctl", k, 64'(octl[k]), 64'(e.ctl));
            check("out_tag", k, 64'(otag[k]), 64'(e.tag));
          end
        end
        if (oil[k]) begin
          if ((k == 0 && iq0.size() == 0) || (k == 1 && iq1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_illegal[%0d]: got tag %0h expected no pulse", k, oitag[k]);
          end else begin
            t = (k == 0) ? iq0.pop_front() : iq1.pop_front();
            check("illegal_tag", k, 64'(oitag[k]), 64'(t));
          end
        end
        stall[k]    = ov[k] && !out_ready[k] && !flush[k];
        snap[k].rs1 = ors1[k];
        snap[k].rs2 = ors2[k];
        snap[k].ctl = octl[k];
        snap[k].tag = otag[k];
      end
    end
  end

  initial begin
    bit ok;
    bit saw_block;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_insn[k] = '0; in_rs1[k] = '0; in_rs2[k] = '0; in_rs3[k] = '0;
      in_tag[k] = '0; flush[k] = 1'b0; rdy_dir[k] = 1'b1; rdy_rand[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Reset state
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", k, 64'(ov[k]), 64'd0);
      check("rst_illegal", k, 64'(oil[k]), 64'd0);
      check("rst_in_ready", k, 64'(oir[k]), 64'd1);
      check("rst_out_rs2", k, ors2[k], 64'd0);
      check("rst_out_tag", k, 64'(otag[k]), 64'd0);
    end
    @(posedge clk);
    #1;

    // ROR register form, one-cycle latency
    send_must(0, 32'h60B0_D0B3, 64'd8, 5'd3);
    @(negedge clk);
    check("ror_valid", 0, 64'(o64_valid), 64'd1);
    check("ror_rs2", 0, o64_rs2, 64'd8);
    check("ror_ctl", 0, {61'd0, o64_i30, o64_i29, o64_i14}, 64'd7);
    check("ror_tag", 0, 64'(o64_tag), 64'd3);
    @(posedge clk);
    #1;

    // SLLI shamt 63: immediate on XLEN=64, illegal on XLEN=32
    send_must(0, 32'h03F0_9093, 64'hDEAD, 5'd4);
    @(negedge clk);
    check("slli_rs2", 0, o64_rs2, 64'd63);
    check("slli_i14", 0, 64'(o64_i14), 64'd0);
    @(posedge clk);
    #1;
    send_must(1, 32'h03F0_9093, 64'hDEAD, 5'd5);
    @(negedge clk);
    check("slli32_illegal", 1, 64'(o32_ill), 64'd1);
    check("slli32_itag", 1, 64'(o32_itag), 64'd5);
    check("slli32_valid", 1, 64'(o32_valid), 64'd0);
    @(posedge clk);
    #1;

    // ADD is rejected with a single illegal pulse
    send_must(0, 32'h0020_81B3, 64'd1, 5'd7);
    @(negedge clk);
    check("add_illegal", 0, 64'(o64_ill), 64'd1);
    check("add_itag", 0, 64'(o64_itag), 64'd7);
    check("add_valid", 0, 64'(o64_valid), 64'd0);
    @(negedge clk);
    check("add_pulse_end", 0, 64'(o64_ill), 64'd0);
    @(posedge clk);
    #1;
    wait_idle(0);

    // Backpressure: four back-to-back ops against a 3+ cycle stall
    rdy_dir[0] = 1'b0;
    saw_block  = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_must(0, 32'h60B0_D0B3 ^ 32'(i << 20), {$urandom, $urandom}, 5'(10 + i));
      end
      begin
        repeat (4) begin
          @(negedge clk);
          if (!o64_ready) saw_block = 1'b1;
        end
        @(posedge clk);
        #1;
        rdy_dir[0] = 1'b1;
      end
    join
    check("bp_in_ready_drop", 0, 64'(saw_block), 64'd1);
    wait_idle(0);

    // Flush with buffered ops, then flush with an illegal op accepted alongside
    rdy_dir[0] = 1'b0;
    send_must(0, 32'h60B0_D0B3, 64'd1, 5'd20);
    send(0, 32'h0200_5033, 64'd2, 64'd2, 64'd2, 5'd21, 2, ok);
    flush_cycle(0, 32'h4000_1033, 5'd22);
    @(negedge clk);
    check("flush_valid", 0, 64'(o64_valid), 64'd0);
    @(posedge clk);
    #1;
    rdy_dir[0] = 1'b1;
    flush_cycle(0, 32'h0020_81B3, 5'd9);
    @(negedge clk);
    check("flush_no_illegal", 0, 64'(o64_ill), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;

    // Asynchronous reset while an op is stalled at the output
    rdy_dir[0] = 1'b0;
    send_must(0, 32'h60B0_D0B3, 64'd5, 5'd25);
    rst = 1'b1;
    #1;
    check("arst_valid", 0, 64'(o64_valid), 64'd0);
    q0.delete(); q1.delete(); iq0.delete(); iq1.delete();
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("arst_in_ready", 0, 64'(o64_ready), 64'd1);
    check("arst_valid_after", 0, 64'(o64_valid), 64'd0);
    rdy_dir[0] = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;

    // Randomized traffic on both widths with random backpressure
    rdy_rand[0] = 1'b1;
    rdy_rand[1] = 1'b1;
    fork
      run_random(0, 300);
      run_random(1, 300);
    join
    rdy_rand[0] = 1'b0;
    rdy_rand[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
